// File: rtl/flash_loader.sv
// Boot-time instruction loader: parses a length/data/checksum byte stream into
// 16-bit flash writes and holds the CPU until the image is verified.
module flash_loader #(
  parameter int FLASH_DEPTH = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [16:0] DEPTH_L = 17'(FLASH_DEPTH);

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DAT_LO,
    DAT_HI,
    CHK_LO,
    CHK_HI,
    DONE,
    ERROR
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [15:0]        r_len;
  logic [7:0]         r_lo;
  logic [15:0]        r_sum;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [15:0]        r_wr_data;

  logic               w_xfer;
  logic [15:0]        w_word;
  logic               w_len_bad;
  logic               w_last_word;

  // Checksum accumulation wraps at 16 bits; the carry out is deliberately lost.
  function automatic logic [15:0] sum16(input logic [15:0] a, input logic [15:0] b);
    return a + b;
  endfunction

  assign w_xfer      = in_valid && in_ready;
  assign w_word      = {in_data, r_lo};
  assign w_len_bad   = (w_word == 16'd0) || ({1'b0, w_word} > DEPTH_L);
  assign w_last_word = ((32'(r_cnt) + 32'd1) == 32'(r_len));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    cpu_hold    = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) w_state_nxt = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) w_state_nxt = w_len_bad ? ERROR : DAT_LO;
      end
      DAT_LO: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) w_state_nxt = DAT_HI;
      end
      DAT_HI: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) w_state_nxt = w_last_word ? CHK_LO : DAT_LO;
      end
      CHK_LO: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) w_state_nxt = CHK_HI;
      end
      CHK_HI: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) w_state_nxt = (w_word == r_sum) ? DONE : ERROR;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_state_nxt = LEN_LO;
      end
      ERROR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
        if (start) w_state_nxt = LEN_LO;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Byte capture, word counter, checksum and the registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_sum     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          LEN_LO, DAT_LO, CHK_LO: r_lo <= in_data;
          LEN_HI: begin
            r_len <= w_word;
            r_cnt <= '0;
            r_sum <= '0;
          end
          DAT_HI: begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_cnt[ADDR_W-1:0];
            r_wr_data <= w_word;
            r_sum     <= sum16(r_sum, w_word);
            r_cnt     <= r_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_flash_loader.sv
// Randomized bench for flash_loader: a stream-level model predicts status and
// writes each cycle; directed loads pin the model with literal results.
module tb_flash_loader;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          cpu_hold;
  logic          done;
  logic          error;

  flash_loader #(.FLASH_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]    stream[$];
  bit            m_init = 1'b0;
  bit            m_busy = 1'b0;
  bit            m_done = 1'b0;
  bit            m_err  = 1'b0;
  bit            m_wexp = 1'b0;
  int            m_k    = 0;
  logic [AW-1:0] m_waddr = '0;
  logic [15:0]   m_wdata = '0;

  logic [15:0]   img [0:DEPTH-1];
  int            wr_cnt = 0;
  int            last_waddr = -1;
  logic [4:0]    act_st, exp_st;

  // Stream-level model: what the loader must do after each clock edge.
  task automatic model_step(input bit rst, input bit st, input bit vld);
    int b;
    int n;
    logic [15:0] s;
    logic [15:0] c;
    m_wexp = 1'b0;
    if (rst) begin
      m_init = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_k = 0;
    end else if (st && !m_busy) begin
      m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0; m_k = 0;
    end else if (vld && m_busy) begin
      b = m_k;
      m_k = m_k + 1;
      if (m_k >= 2) begin
        n = int'({stream[1], stream[0]});
        if (n == 0 || n > DEPTH) begin
          m_busy = 1'b0; m_err = 1'b1;
        end else begin
          if (b >= 3 && b <= 2*n+1 && (b % 2) == 1) begin
            m_wexp  = 1'b1;
            m_waddr = AW'((b - 3) / 2);
            m_wdata = {stream[b], stream[b-1]};
          end
          if (m_k == 2*n + 4) begin
            s = 16'h0;
            for (int i = 0; i < n; i++) s = s + {stream[3+2*i], stream[2+2*i]};
            c = {stream[2*n+3], stream[2*n+2]};
            m_busy = 1'b0;
            m_done = (s == c);
            m_err  = (s != c);
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit st, input bit vld, input logic [7:0] d);
    reset = rst; start = st; in_valid = vld; in_data = d;
    @(posedge clk);
    model_step(rst, st, vld);
    #1;
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      act_st = {in_ready, cpu_hold, done, error, wr_en};
      exp_st = {m_busy, m_busy | m_err, m_done, m_err, m_wexp};
      n_cmp++;
      if (act_st !== exp_st) begin
        n_bad++;
        $display("FAIL status t=%0t {rdy,hold,done,err,wr_en} got %b want %b", $time, act_st, exp_st);
      end
      if (m_wexp) begin
        n_cmp++;
        if ({wr_addr, wr_data} !== {m_waddr, m_wdata}) begin
          n_bad++;
          $display("FAIL write t=%0t got addr %0d data %h want addr %0d data %h",
                   $time, wr_addr, wr_data, m_waddr, m_wdata);
        end
      end
      if (wr_en === 1'b1) begin
        wr_cnt++;
        img[wr_addr] = wr_data;
        last_waddr = int'(wr_addr);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // mode 0: random in_valid, 1: toggling, 2: always valid
  task automatic run_load(input int mode);
    int guard;
    bit v;
    bit tg;
    guard = 0;
    tg = 1'b0;
    wr_cnt = 0;
    cyc(0, 1, 0, 8'h00);
    while (m_busy && guard < 20000) begin
      case (mode)
        0:       v = ($urandom_range(0, 3) != 0);
        1:       begin tg = ~tg; v = tg; end
        default: v = 1'b1;
      endcase
      cyc(0, ($urandom_range(0, 15) == 0), v, v ? stream[m_k] : 8'($urandom));
      guard++;
    end
    if (m_busy) begin
      n_cmp++; n_bad++;
      $display("FAIL load_timeout got busy after %0d cycles want finished", guard);
      m_busy = 1'b0;
    end
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
  endtask

  task automatic set_basic(input logic [7:0] chk_lo);
    stream = {};
    stream.push_back(8'h02); stream.push_back(8'h00);
    stream.push_back(8'h01); stream.push_back(8'h60);
    stream.push_back(8'h00); stream.push_back(8'h60);
    stream.push_back(chk_lo); stream.push_back(8'hC0);
  endtask

  initial begin
    int n;
    logic [15:0] w;
    logic [15:0] s;

    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'h00);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);

    set_basic(8'h01);
    run_load(2);
    check("basic_w0", 32'(img[0]), 32'h6001);
    check("basic_w1", 32'(img[1]), 32'h6000);
    check("basic_nwr", 32'(wr_cnt), 32'd2);
    check("basic_done", 32'({done, cpu_hold, error}), 32'b100);

    set_basic(8'h02);
    run_load(0);
    check("badchk_nwr", 32'(wr_cnt), 32'd2);
    check("badchk_flags", 32'({done, cpu_hold, error}), 32'b011);

    stream = {}; stream.push_back(8'h00); stream.push_back(8'h00);
    run_load(2);
    check("len0_nwr", 32'(wr_cnt), 32'd0);
    check("len0_err", 32'(error), 32'h1);
    stream = {}; stream.push_back(8'h01); stream.push_back(8'h04);
    run_load(0);
    check("len1025_nwr", 32'(wr_cnt), 32'd0);
    check("len1025_err", 32'(error), 32'h1);

    img[0] = 16'h0; img[1] = 16'h0;
    set_basic(8'h01);
    run_load(1);
    check("bp_w0", 32'(img[0]), 32'h6001);
    check("bp_w1", 32'(img[1]), 32'h6000);
    check("bp_nwr", 32'(wr_cnt), 32'd2);
    check("bp_done", 32'({done, cpu_hold, error}), 32'b100);

    stream = {}; stream.push_back(8'h00); stream.push_back(8'h04);
    for (int i = 0; i < DEPTH; i++) begin stream.push_back(8'hFF); stream.push_back(8'hFF); end
    stream.push_back(8'h00); stream.push_back(8'hFC);
    run_load(0);
    check("full_last_addr", 32'(last_waddr), 32'd1023);
    check("full_nwr", 32'(wr_cnt), 32'd1024);
    check("full_done", 32'(done), 32'h1);

    set_basic(8'h01);
    wr_cnt = 0;
    cyc(0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, stream[m_k]);
    cyc(1, 0, 1, 8'h60);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'($urandom));
    check("rstmid_nwr", 32'(wr_cnt), 32'd1);
    check("rstmid_idle", 32'({in_ready, cpu_hold, done, error}), 32'b0000);
    img[0] = 16'h0; img[1] = 16'h0;
    run_load(0);
    check("reload_w0", 32'(img[0]), 32'h6001);
    check("reload_w1", 32'(img[1]), 32'h6000);
    check("reload_done", 32'(done), 32'h1);

    for (int t = 0; t < 14; t++) begin
      case ($urandom_range(0, 9))
        0:       n = 0;
        1:       n = DEPTH + 1 + int'($urandom_range(0, 1000));
        default: n = int'($urandom_range(1, 12));
      endcase
      stream = {};
      stream.push_back(8'(n)); stream.push_back(8'(n >> 8));
      s = 16'h0;
      if (n >= 1 && n <= DEPTH) begin
        for (int i = 0; i < n; i++) begin
          w = 16'($urandom);
          s = s + w;
          stream.push_back(w[7:0]); stream.push_back(w[15:8]);
        end
        if ($urandom_range(0, 3) == 0) s = s ^ (16'h1 << $urandom_range(0, 15));
        stream.push_back(s[7:0]); stream.push_back(s[15:8]);
      end
      run_load(int'($urandom_range(0, 2)));
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
